// File: rtl/picorv_memarb.sv
// Round-robin arbiter sharing one registered external memory bus between the
// fetch client (0) and the load/store client (1).
module picorv_memarb #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            c0_reqst,
  input  logic            c1_reqst,
  output logic            c0_grant,
  output logic            c1_grant,
  input  logic            c0_valid,
  input  logic            c1_valid,
  output logic            c0_ready,
  output logic            c1_ready,
  input  logic [XLEN-1:0] c0_addr,
  input  logic [XLEN-1:0] c1_addr,
  input  logic [31:0]     c0_wdata,
  input  logic [31:0]     c1_wdata,
  input  logic [3:0]      c0_wstrb,
  input  logic [3:0]      c1_wstrb,
  output logic [31:0]     c0_rdata,
  output logic [31:0]     c1_rdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [31:0]     mem_rdata
);

  // Ownership states:  IDLE | no grant ; OWN0 | client 0 owns ; OWN1 | client 1 owns
  // Transaction states: T_IDLE | bus free ; T_BUS | mem_valid up ; T_RESP | ready pulse
  // Encodings put each grant / mem_valid directly on a state flop.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] OWN0   = 2'b01;
  localparam logic [1:0] OWN1   = 2'b10;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUS  = 2'b01;
  localparam logic [1:0] T_RESP = 2'b10;

  logic [1:0]      r_own, w_own_nxt;
  logic            r_last_owner, w_last_owner_nxt;
  logic [1:0]      r_txn, w_txn_nxt;
  logic            w_busy, w_launch, w_done;
  logic [XLEN-1:0] r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic [3:0]      r_mem_wstrb;
  logic [31:0]     r_c0_rdata, r_c1_rdata;

  assign w_busy   = (r_txn != T_IDLE);
  // Launch also needs reqst so a releasing owner never starts a transfer.
  assign w_launch = (r_txn == T_IDLE) &&
                    ((r_own[0] && c0_reqst && c0_valid) ||
                     (r_own[1] && c1_reqst && c1_valid));
  assign w_done   = (r_txn == T_BUS) && mem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_own        <= IDLE;
      r_last_owner <= 1'b1;
    end else begin
      r_own        <= w_own_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  always_comb begin
    w_own_nxt        = r_own;
    w_last_owner_nxt = r_last_owner;
    case (r_own)
      IDLE: begin
        if (c0_reqst && c1_reqst) w_own_nxt = r_last_owner ? OWN0 : OWN1;
        else if (c0_reqst)        w_own_nxt = OWN0;
        else if (c1_reqst)        w_own_nxt = OWN1;
      end
      OWN0: begin
        if (!c0_reqst && !w_busy) begin
          w_own_nxt        = c1_reqst ? OWN1 : IDLE;
          w_last_owner_nxt = 1'b0;
        end
      end
      OWN1: begin
        if (!c1_reqst && !w_busy) begin
          w_own_nxt        = c0_reqst ? OWN0 : IDLE;
          w_last_owner_nxt = 1'b1;
        end
      end
      default: w_own_nxt = IDLE;
    endcase
  end

  always_comb begin
    c0_grant = r_own[0];
    c1_grant = r_own[1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_txn <= T_IDLE;
    else       r_txn <= w_txn_nxt;
  end

  always_comb begin
    w_txn_nxt = r_txn;
    case (r_txn)
      T_IDLE:  if (w_launch) w_txn_nxt = T_BUS;
      T_BUS:   if (mem_ready) w_txn_nxt = T_RESP;
      T_RESP:  w_txn_nxt = T_IDLE;
      default: w_txn_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    mem_valid = r_txn[0];
    c0_ready  = r_txn[1] && r_own[0];
    c1_ready  = r_txn[1] && r_own[1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_c0_rdata  <= '0;
      r_c1_rdata  <= '0;
    end else begin
      if (w_launch) begin
        r_mem_addr  <= r_own[1] ? c1_addr  : c0_addr;
        r_mem_wdata <= r_own[1] ? c1_wdata : c0_wdata;
        r_mem_wstrb <= r_own[1] ? c1_wstrb : c0_wstrb;
      end
      if (w_done && (r_mem_wstrb == 4'b0000)) begin
        if (r_own[1]) r_c1_rdata <= mem_rdata;
        else          r_c0_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign c0_rdata  = r_c0_rdata;
  assign c1_rdata  = r_c1_rdata;

endmodule

// File: tb/tb_picorv_memarb.sv
// Bench for picorv_memarb: directed protocol scenarios, then two randomized
// clients against a memory reference model with queue-based scoreboarding.
module tb_picorv_memarb;

  localparam int ITER = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  reqst = 2'b00;
  logic [1:0]  valid = 2'b00;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  wire  [1:0]  grant, ready;
  wire  [31:0] rdata0, rdata1;
  wire         mem_valid;
  logic        mem_ready = 1'b0;
  wire  [31:0] mem_addr, mem_wdata;
  wire  [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        auto_bus = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } bus_t;

  bus_t        bus_q [$];
  logic [31:0] resp_q0 [$];
  logic [31:0] resp_q1 [$];
  logic [31:0] exp_rd [2];
  logic [31:0] ref_mem [int];
  logic [31:0] bus_mem [int];

  always #5 clock = ~clock;

  picorv_memarb #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .c0_reqst(reqst[0]), .c1_reqst(reqst[1]),
    .c0_grant(grant[0]), .c1_grant(grant[1]),
    .c0_valid(valid[0]), .c1_valid(valid[1]),
    .c0_ready(ready[0]), .c1_ready(ready[1]),
    .c0_addr(addr[0]), .c1_addr(addr[1]),
    .c0_wdata(wdata[0]), .c1_wdata(wdata[1]),
    .c0_wstrb(wstrb[0]), .c1_wstrb(wstrb[1]),
    .c0_rdata(rdata0), .c1_rdata(rdata1),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                       input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(int'(a))) return bus_mem[int'(a)];
    return init_word(a);
  endfunction

  // Monitor: bus launches, field stability, completions.
  initial begin
    bus_t        cur;
    logic        prev;
    logic [31:0] e;
    prev = 1'b0;
    cur  = '{a: 32'h0, d: 32'h0, s: 4'h0};
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("grant_exclusive", {31'b0, grant[0] & grant[1]}, 32'h0);
        if (mem_valid && !prev) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_launch unexpected addr=%h", mem_addr);
          end else begin
            cur = bus_q.pop_front();
            check("bus_addr", mem_addr, cur.a);
            check("bus_wdata", mem_wdata, cur.d);
            check("bus_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.s});
          end
        end else if (mem_valid && prev) begin
          check("bus_stable_addr", mem_addr, cur.a);
          check("bus_stable_wdata", mem_wdata, cur.d);
          check("bus_stable_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.s});
        end
        if (ready[0]) begin
          if (resp_q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL c0_ready unexpected rdata=%h", rdata0);
          end else begin
            e = resp_q0.pop_front();
            check("c0_resp_rdata", rdata0, e);
          end
        end
        if (ready[1]) begin
          if (resp_q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL c1_ready unexpected rdata=%h", rdata1);
          end else begin
            e = resp_q1.pop_front();
            check("c1_resp_rdata", rdata1, e);
          end
        end
      end
      prev = mem_valid;
    end
  end

  // Memory responder with random wait states and spurious idle mem_ready.
  initial begin
    int wc;
    wc = 0;
    forever begin
      @(negedge clock);
      if (auto_bus) begin
        if (mem_valid && !reset) begin
          if (wc == 0) begin
            mem_ready = 1'b1;
            mem_rdata = (mem_wstrb == 4'h0) ? bus_rd(mem_addr) : $urandom;
            if (mem_wstrb != 4'h0)
              bus_mem[int'(mem_addr)] = merge(bus_rd(mem_addr), mem_wdata, mem_wstrb);
            wc = $urandom_range(0, 3);
          end else begin
            wc--;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
          end
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push_txn(input int c, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] rd_val);
    addr[c]  = a;
    wdata[c] = d;
    wstrb[c] = s;
    bus_q.push_back('{a: a, d: d, s: s});
    if (s == 4'h0) exp_rd[c] = rd_val;
    if (c == 0) resp_q0.push_back(exp_rd[0]);
    else        resp_q1.push_back(exp_rd[1]);
  endtask

  task automatic assert_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    reqst = 2'b00;
    valid = 2'b00;
    bus_q.delete();
    resp_q0.delete();
    resp_q1.delete();
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
  endtask

  task automatic client(input int c);
    logic [31:0] a, d, rv;
    logic [3:0]  s;
    int          n;
    repeat (ITER) begin
      repeat ($urandom_range(1, 4)) @(negedge clock);
      reqst[c] = 1'b1;
      n = 0;
      while (!grant[c] && n < 200) begin
        @(negedge clock);
        n++;
      end
      check($sformatf("c%0d_grant_wait", c), {31'b0, grant[c]}, 32'h1);
      if (grant[c]) begin
        repeat ($urandom_range(1, 3)) begin
          a  = 32'($urandom_range(0, 15)) << 2;
          d  = $urandom;
          s  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          rv = ref_rd(a);
          if (s != 4'h0) ref_mem[int'(a)] = merge(rv, d, s);
          push_txn(c, a, d, s, rv);
          valid[c] = 1'b1;
          n = 0;
          do begin
            @(negedge clock);
            n++;
          end while (!ready[c] && n < 50);
          check($sformatf("c%0d_ready_wait", c), {31'b0, ready[c]}, 32'h1);
          valid[c] = 1'b0;
        end
      end
      reqst[c] = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i] = 32'h0; wdata[i] = 32'h0; wstrb[i] = 4'h0; exp_rd[i] = 32'h0;
    end

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_grant", {30'b0, grant}, 32'h0);
    check("rst_ready", {30'b0, ready}, 32'h0);
    check("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    #1 reset = 1'b0;

    // Single request latency
    reqst[1] = 1'b1;
    @(negedge clock);
    check("single_grant", {30'b0, grant}, 32'h2);
    reqst[1] = 1'b0;
    @(negedge clock);
    check("single_release", {30'b0, grant}, 32'h0);

    // Tie from reset, handover, round robin
    assert_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    reqst = 2'b11;
    @(negedge clock);
    check("tie_c0_wins", {30'b0, grant}, 32'h1);
    @(negedge clock);
    @(negedge clock);
    check("tie_c0_holds", {30'b0, grant}, 32'h1);
    reqst[0] = 1'b0;
    @(negedge clock);
    check("handover_to_c1", {30'b0, grant}, 32'h2);
    reqst[0] = 1'b1;
    reqst[1] = 1'b0;
    @(negedge clock);
    check("handover_to_c0", {30'b0, grant}, 32'h1);
    reqst[0] = 1'b0;
    reqst[1] = 1'b1;
    @(negedge clock);
    check("handover_back_c1", {30'b0, grant}, 32'h2);

    // Read by client 1
    push_txn(1, 32'h0000_1004, 32'h5555_AAAA, 4'h0, 32'hDEAD_BEEF);
    valid[1] = 1'b1;
    @(negedge clock);
    check("rd_mem_valid", {31'b0, mem_valid}, 32'h1);
    check("rd_mem_addr", mem_addr, 32'h0000_1004);
    check("rd_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    check("rd_mem_valid_clr", {31'b0, mem_valid}, 32'h0);
    check("rd_ready", {30'b0, ready}, 32'h2);
    check("rd_rdata1", rdata1, 32'hDEAD_BEEF);
    check("rd_rdata0_untouched", rdata0, 32'h0);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    valid[1] = 1'b0;
    @(negedge clock);
    check("rd_ready_pulse_end", {30'b0, ready}, 32'h0);

    // Write by client 0 with three wait states
    reqst = 2'b01;
    @(negedge clock);
    check("wr_grant_c0", {30'b0, grant}, 32'h1);
    push_txn(0, 32'h20, 32'h1122_3344, 4'b0011, 32'h0);
    valid[0] = 1'b1;
    @(negedge clock);
    check("wr_mem_valid", {31'b0, mem_valid}, 32'h1);
    check("wr_mem_wdata", mem_wdata, 32'h1122_3344);
    check("wr_mem_wstrb", {28'b0, mem_wstrb}, 32'h3);
    repeat (3) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      @(negedge clock);
      check("wr_wait_valid", {31'b0, mem_valid}, 32'h1);
      check("wr_wait_addr", mem_addr, 32'h20);
      check("wr_wait_no_ready", {30'b0, ready}, 32'h0);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clock);
    check("wr_ready", {30'b0, ready}, 32'h1);
    check("wr_rdata0_kept", rdata0, 32'h0);
    mem_ready = 1'b0;
    valid[0] = 1'b0;
    @(negedge clock);
    check("wr_single_pulse", {30'b0, ready}, 32'h0);

    // Owner drops reqst mid-transaction; non-owner valid ignored
    push_txn(0, 32'h40, 32'h0, 4'h0, 32'h0BAD_F00D);
    valid[0] = 1'b1;
    @(negedge clock);
    check("viol_mem_valid", {31'b0, mem_valid}, 32'h1);
    reqst = 2'b10;
    @(negedge clock);
    check("viol_grant_held", {30'b0, grant}, 32'h1);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    @(negedge clock);
    check("viol_ready", {30'b0, ready}, 32'h1);
    check("viol_grant_at_ready", {30'b0, grant}, 32'h1);
    valid[0] = 1'b0;
    mem_ready = 1'b0;
    addr[1] = 32'h80;
    wstrb[1] = 4'hF;
    valid[1] = 1'b1;
    @(negedge clock);
    check("nonowner_no_bus_a", {31'b0, mem_valid}, 32'h0);
    @(negedge clock);
    check("viol_released", {30'b0, grant}, 32'h2);
    check("nonowner_no_bus_b", {31'b0, mem_valid}, 32'h0);
    valid[1] = 1'b0;

    // Reset in the middle of a bus transaction
    push_txn(1, 32'h80, 32'h0, 4'h0, 32'h1234_5678);
    valid[1] = 1'b1;
    @(negedge clock);
    check("mid_mem_valid", {31'b0, mem_valid}, 32'h1);
    #2 reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("async_mem_valid", {31'b0, mem_valid}, 32'h0);
    check("async_grant", {30'b0, grant}, 32'h0);
    check("async_ready", {30'b0, ready}, 32'h0);
    check("async_rdata1", rdata1, 32'h0);
    reqst = 2'b00;
    valid = 2'b00;
    bus_q.delete();
    resp_q0.delete();
    resp_q1.delete();
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    repeat (2) begin
      @(negedge clock);
      check("inrst_mem_valid", {31'b0, mem_valid}, 32'h0);
      check("inrst_ready", {30'b0, ready}, 32'h0);
    end
    @(negedge clock);
    #1 reset = 1'b0;
    mem_ready = 1'b0;
    reqst = 2'b11;
    @(negedge clock);
    check("post_rst_tie", {30'b0, grant}, 32'h1);
    check("post_rst_no_ready", {30'b0, ready}, 32'h0);
    reqst = 2'b00;
    @(negedge clock);
    @(negedge clock);
    check("post_rst_idle", {30'b0, grant}, 32'h0);

    // Randomized two-client traffic
    auto_bus = 1'b1;
    fork
      client(0);
      client(1);
    join
    repeat (6) @(negedge clock);
    check("end_bus_q_empty", bus_q.size(), 32'h0);
    check("end_resp_q0_empty", resp_q0.size(), 32'h0);
    check("end_resp_q1_empty", resp_q1.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
